// File: rtl/quiz_disp_pkg.sv
// Shared glyph definitions, converter states and helpers for the quiz score scanner.
// Segment constants are active-high in {g,f,e,d,c,b,a} order.
package quiz_disp_pkg;

    localparam int unsigned MaxPlayers = 9;

    localparam logic [6:0] SegD0    = 7'h3F;
    localparam logic [6:0] SegD1    = 7'h06;
    localparam logic [6:0] SegD2    = 7'h5B;
    localparam logic [6:0] SegD3    = 7'h4F;
    localparam logic [6:0] SegD4    = 7'h66;
    localparam logic [6:0] SegD5    = 7'h6D;
    localparam logic [6:0] SegD6    = 7'h7D;
    localparam logic [6:0] SegD7    = 7'h07;
    localparam logic [6:0] SegD8    = 7'h7F;
    localparam logic [6:0] SegD9    = 7'h6F;
    localparam logic [6:0] SegDash  = 7'h40;
    localparam logic [6:0] SegLetO  = 7'h5C;
    localparam logic [6:0] SegLetN  = 7'h54;
    localparam logic [6:0] SegBlank = 7'h00;

    typedef enum logic [3:0] {
        DIG0, DIG1, DIG2, DIG3, DIG4, DIG5, DIG6, DIG7, DIG8, DIG9,
        DASH, LET_O, LET_N, BLANK
    } glyph_e;

    typedef enum logic [1:0] {StIdle, StShift, StDone} conv_state_e;

    function automatic logic [3:0] onehot_to_index(input logic [MaxPlayers-1:0] vec);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < MaxPlayers; i++) begin
            if (vec[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    function automatic logic [6:0] glyph_segs(input glyph_e code);
        case (code)
            DIG0:    return SegD0;
            DIG1:    return SegD1;
            DIG2:    return SegD2;
            DIG3:    return SegD3;
            DIG4:    return SegD4;
            DIG5:    return SegD5;
            DIG6:    return SegD6;
            DIG7:    return SegD7;
            DIG8:    return SegD8;
            DIG9:    return SegD9;
            DASH:    return SegDash;
            LET_O:   return SegLetO;
            LET_N:   return SegLetN;
            default: return SegBlank;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: MARK_W shift cycles then a one-cycle done pulse.
// Input must already be limited to 0..99 so two BCD digits suffice.
module bin2bcd_seq
    import quiz_disp_pkg::*;
#(
    parameter int unsigned MARK_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] bin,
    output logic       busy,
    output logic       done,
    output logic [3:0] tens,
    output logic [3:0] units
);

    localparam int unsigned CntW = $clog2(MARK_W + 1);

    conv_state_e     state_q, state_d;
    logic [7:0]      bcd_q, bcd_d;
    logic [6:0]      sh_q, sh_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      adj;

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        adj     = bcd_q;
        if (adj[3:0] >= 4'd5) adj[3:0] = adj[3:0] + 4'd3;
        if (adj[7:4] >= 4'd5) adj[7:4] = adj[7:4] + 4'd3;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    bcd_d   = '0;
                    // MSB of the MARK_W-bit value lands in sh_q[6]
                    sh_d    = bin << (7 - MARK_W);
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                {bcd_d, sh_d} = {adj, sh_q} << 1;
                cnt_d         = cnt_q + CntW'(1);
                if (cnt_q == CntW'(MARK_W - 1)) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            bcd_q   <= '0;
            sh_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy  = (state_q != StIdle);
    assign done  = (state_q == StDone);
    assign tens  = bcd_q[7:4];
    assign units = bcd_q[3:0];

endmodule

// File: rtl/quiz_score_scanner.sv
// Multiplexed common-anode driver showing the answering player and score as "SS P. o n".
// Score snapshots are taken once per frame; a blink burst marks every change of answerer.
module quiz_score_scanner
    import quiz_disp_pkg::*;
#(
    parameter int unsigned N_PLAYERS    = 4,
    parameter int unsigned MARK_W       = 4,
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_PLAYERS-1:0]        answer,
    input  logic [N_PLAYERS*MARK_W-1:0] marks,
    output logic [7:0]                  dig,
    output logic [7:0]                  seg
);

    localparam int unsigned ScanW  = $clog2(SCAN_DIV);
    localparam int unsigned BlinkW = $clog2(BLINK_FRAMES);

    logic [N_PLAYERS-1:0] ans_q, last_q;
    logic [ScanW-1:0]     scan_q;
    logic [2:0]           slot_q;
    logic [BlinkW-1:0]    blink_q;
    logic [3:0]           player_snap_q, disp_player_q, disp_tens_q, disp_units_q;
    logic                 disp_valid_q;
    logic [7:0]           dig_q, seg_q, dig_d, seg_d;

    logic                 ans_valid, tick, frame_end, trigger, blank, dp;
    logic                 conv_start, conv_busy, conv_done;
    logic [3:0]           idx, conv_tens, conv_units;
    logic [MARK_W-1:0]    sel_mark;
    logic [6:0]           sat_mark;
    glyph_e               code;

    assign ans_valid  = (ans_q != '0) && ((ans_q & (ans_q - N_PLAYERS'(1))) == '0);
    assign tick       = (scan_q == ScanW'(SCAN_DIV - 1));
    assign frame_end  = tick && (slot_q == 3'd4);
    assign conv_start = frame_end && ans_valid && !conv_busy;
    assign trigger    = ans_valid && (ans_q != last_q);
    assign blank      = (blink_q != '0) && blink_q[3];
    assign idx        = onehot_to_index(MaxPlayers'(ans_q));

    always_comb begin
        sel_mark = '0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            if (ans_q[i]) sel_mark = marks[i*MARK_W +: MARK_W];
        end
        sat_mark = (7'(sel_mark) > 7'd99) ? 7'd99 : 7'(sel_mark);
    end

    bin2bcd_seq #(
        .MARK_W(MARK_W)
    ) u_bcd (
        .clk  (clk),
        .rst  (rst),
        .start(conv_start),
        .bin  (sat_mark),
        .busy (conv_busy),
        .done (conv_done),
        .tens (conv_tens),
        .units(conv_units)
    );

    always_comb begin
        code = BLANK;
        dp   = 1'b0;
        case (slot_q)
            3'd0: code = disp_valid_q ? glyph_e'(disp_units_q) : DASH;
            3'd1: code = disp_valid_q ? glyph_e'(disp_tens_q) : DASH;
            3'd2: begin
                code = disp_valid_q ? glyph_e'(disp_player_q) : DASH;
                dp   = disp_valid_q;
            end
            3'd3:    code = LET_O;
            3'd4:    code = LET_N;
            default: code = BLANK;
        endcase
        seg_d = ~{dp, glyph_segs(code)};
        dig_d = blank ? 8'hFF : ~(8'h01 << slot_q);
    end

    always_ff @(posedge clk) begin
        ans_q <= answer;
        if (rst) begin
            scan_q        <= '0;
            slot_q        <= '0;
            blink_q       <= '0;
            last_q        <= '0;
            player_snap_q <= '0;
            disp_valid_q  <= 1'b0;
            disp_player_q <= '0;
            disp_tens_q   <= '0;
            disp_units_q  <= '0;
            dig_q         <= 8'hFF;
            seg_q         <= 8'hFF;
        end else begin
            scan_q <= tick ? '0 : scan_q + ScanW'(1);
            if (tick) begin
                slot_q <= (slot_q == 3'd4) ? 3'd0 : slot_q + 3'd1;
                dig_q  <= dig_d;
                seg_q  <= seg_d;
            end
            if (trigger) begin
                blink_q <= BlinkW'(BLINK_FRAMES - 1);
                last_q  <= ans_q;
            end else if (frame_end && (blink_q != '0)) begin
                blink_q <= blink_q - BlinkW'(1);
            end
            if (conv_start) player_snap_q <= idx + 4'd1;
            // Invalid answer blanks the value at a frame boundary; stored digits are kept.
            if (frame_end && !ans_valid) disp_valid_q <= 1'b0;
            if (conv_done) begin
                disp_valid_q  <= 1'b1;
                disp_player_q <= player_snap_q;
                disp_tens_q   <= conv_tens;
                disp_units_q  <= conv_units;
            end
        end
    end

    assign dig = dig_q;
    assign seg = seg_q;

endmodule
